// File: rtl/lane_gather_reader.sv
// lane_gather_reader: captures N_LANES x WIDTH lanes from a packed parallel
// bus in one cycle. It then streams lanes 0, STEP, 2*STEP, ... (all below
// N_LANES) one beat at a time over a valid/ready interface.
// Ports:
//   i_clk, i_rst  clock (rising edge); asynchronous active-high reset
//   i_load        capture request, honoured only in IDLE
//   i_data        packed lanes, lane k = i_data[k*WIDTH +: WIDTH]
//   o_busy        high whenever the block is not IDLE
//   o_valid       beat valid
//   i_ready       consumer ready
//   o_data        value of the current lane
//   o_index       index of the current lane
//   o_last        current beat is the final beat of the burst
//   o_done        one-cycle pulse after the final handshake
module lane_gather_reader #(
    parameter int N_LANES = 10,
    parameter int WIDTH   = 8,
    parameter int STEP    = 1,
    parameter int IDX_W   = $clog2(N_LANES + STEP)
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_load,
    input  logic [N_LANES*WIDTH-1:0]   i_data,
    output logic                       o_busy,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [WIDTH-1:0]           o_data,
    output logic [IDX_W-1:0]           o_index,
    output logic                       o_last,
    output logic                       o_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [IDX_W-1:0]         idx_nxt;
    logic                     capture;
    logic                     last;
    logic [WIDTH-1:0]         lane_sel;
    logic [N_LANES*WIDTH-1:0] lane_flat;

    assign capture = (state_q == IDLE) && i_load;

    // IDX_W holds idx+STEP, so neither the sum nor the compare can wrap.
    assign idx_nxt = idx_q + IDX_W'(STEP);
    assign last    = (idx_nxt >= IDX_W'(N_LANES));

    for (genvar k = 0; k < N_LANES; k++) begin : g_lane
        logic [WIDTH-1:0] lane_q, lane_d;

        always_comb begin
            lane_d = lane_q;
            if (capture) begin
                lane_d = i_data[k*WIDTH +: WIDTH];
            end
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                lane_q <= '0;
            end else begin
                lane_q <= lane_d;
            end
        end

        assign lane_flat[k*WIDTH +: WIDTH] = lane_q;
    end

    // Only indices that name a real lane can select data.
    always_comb begin
        lane_sel = '0;
        for (int k = 0; k < N_LANES; k++) begin
            if (idx_q == IDX_W'(k)) begin
                lane_sel = lane_flat[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        o_valid = 1'b0;
        o_data  = '0;
        o_index = '0;
        o_last  = 1'b0;
        o_done  = 1'b0;
        o_busy  = (state_q != IDLE);
        unique case (state_q)
            IDLE: begin
                if (i_load) begin
                    state_d = SEND;
                    idx_d   = '0;
                end
            end
            SEND: begin
                o_valid = 1'b1;
                o_data  = lane_sel;
                o_index = idx_q;
                o_last  = last;
                if (i_ready) begin
                    if (last) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_nxt;
                    end
                end
            end
            DONE: begin
                o_done  = 1'b1;
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

endmodule

// File: doc/lane_gather_reader.md
Name: lane_gather_reader

Overview:
Reader side of the per-lane generate-register pattern. A generate-for builds one capture register per lane, and all lanes load from a packed parallel bus in a single cycle. A small FSM then streams the captured lanes out one at a time over a valid/ready interface, visiting lane indices 0, STEP, 2*STEP, and so on below N_LANES. It sits between a wide parallel producer and a narrow serial consumer.

Parameters:
N_LANES, 10, number of lanes (>=1)
WIDTH, 8, bits per lane
STEP, 1, lane stride (1 <= STEP <= N_LANES); beats per burst = ceil(N_LANES/STEP)
IDX_W, $clog2(N_LANES+STEP), index width; wide enough to hold idx+STEP without overflow

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, asynchronous, active-high
i_load  input  1  capture request
i_data  input  N_LANES*WIDTH  packed lanes; lane k = i_data[k*WIDTH +: WIDTH]
o_busy  output  1  high whenever state != IDLE
o_valid  output  1  beat valid
i_ready  input  1  consumer ready
o_data  output  WIDTH  current lane value
o_index  output  IDX_W  current lane index
o_last  output  1  current beat is the final beat of the burst
o_done  output  1  one-cycle pulse after the final handshake

Behaviour:
- Reset (async assert on i_rst, not gated by the clock):
  - all lane registers = 0
  - state = IDLE, idx = 0
  - o_valid, o_last, o_done, o_busy = 0; o_data = 0; o_index = 0
- Lane storage:
  - generate-for k in 0..N_LANES-1 creates one WIDTH register lane[k]
  - every lane is written only on the capture cycle
- FSM states: IDLE, SEND, DONE.
- IDLE:
  - if i_load=1: on the next edge all lane[k] <= i_data slice k, idx <= 0, state <= SEND.
  - i_load is ignored in SEND and DONE; lanes are not overwritten.
- SEND:
  - o_valid=1, o_data=lane[idx], o_index=idx.
  - o_last=1 iff idx+STEP >= N_LANES.
  - Handshake = o_valid & i_ready, sampled at the edge.
  - On handshake with o_last=0: idx <= idx+STEP, stay in SEND.
  - On handshake with o_last=1: state <= DONE.
  - While o_valid & !i_ready: o_data, o_index and o_last hold stable.
- DONE:
  - o_done=1 for exactly one cycle, o_valid=0, then state <= IDLE.
  - i_load in the DONE cycle is ignored.
- Timing:
  - First beat is valid in the cycle after the capture edge, so load-to-first-valid latency is 1 cycle.
  - Throughput is 1 beat/cycle while i_ready=1.
  - With i_ready held high, a burst occupies ceil(N_LANES/STEP) SEND cycles plus 1 DONE cycle.
- Outputs are combinational decodes of state, idx and lane registers only; there is no combinational path from i_ready to o_valid.
- Index arithmetic:
  - idx+STEP is computed at IDX_W bits and never wraps.
  - Indices >= N_LANES are never presented.
  - o_data mux reads only valid lane indices.
- Degenerate case STEP = N_LANES: a single beat (lane 0) with o_last=1.
- Reset mid-burst: immediately returns to IDLE with all outputs and lanes 0; no o_done pulse is emitted.
- i_rst deassertion is synchronised externally; the block only requires async assert.

Test Plan:
- Reset, then idle: i_rst pulse, i_load=0 -> o_valid=0, o_busy=0, o_done=0, o_data=0 for 5 cycles.
- Default burst (N_LANES=10, STEP=1): lane k = 8'hA0+k, one-cycle i_load, i_ready=1:
  - 10 consecutive beats, o_index 0..9, o_data A0..A9
  - o_last only on index 9
  - o_done one cycle later, then o_busy=0
- Stride (STEP=2): same data -> 5 beats, o_index 0,2,4,6,8, data A0,A2,A4,A6,A8, o_last on index 8.
- Backpressure: i_ready=0 for 3 cycles at index 4:
  - o_valid=1, o_data=A4, o_index=4 stable for all 3 cycles
  - index advances only after i_ready=1
  - total beats unchanged
- Load during burst: new i_data (lanes = 8'h55) with i_load=1 at index 3 -> ignored; remaining beats still A3..A9.
- Reset mid-burst at index 6: i_rst pulse -> same cycle o_valid=0, o_busy=0, lanes cleared. A subsequent load/burst starts at index 0, and no o_done is emitted for the aborted burst.
